// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory model: block and address widths, defaults, FSM encodings.
package data_memory_pkg;

    localparam int unsigned DATA_MEM_BLOCK_W = 128;
    localparam int unsigned DATA_MEM_ADDR_W  = 28;
    localparam int unsigned DATA_MEM_DEPTH   = 256;
    localparam int unsigned DATA_MEM_LATENCY = 5;
    localparam int unsigned STATE_W          = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUSY  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;
    localparam logic [STATE_W-1:0] ST_CLEAR = 2'd3;

    typedef logic [DATA_MEM_BLOCK_W-1:0] block_t;

    // Down-counter width able to hold LATENCY-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Cache-to-memory block interface (mem_read/mem_write/mem_address/mem_busywait bundle).
interface data_memory_if
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = DATA_MEM_ADDR_W
) ();

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    block_t            writedata;
    block_t            readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );

endinterface

// File: rtl/data_mem_latency_counter.sv
// Loadable down-counter with zero flag; models fixed access latency for the memory models.
module data_mem_latency_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             enable_i,
    output logic             zero_c_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c_o = (count_q == '0);

endmodule

// File: rtl/data_memory.sv
// Block-granular backing store behind the data cache with fixed multi-cycle latency.
// Optional power-up zeroing sweep enabled by defining DATA_MEM_CLEAR_EN.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH   = DATA_MEM_DEPTH,
    parameter int unsigned LATENCY = DATA_MEM_LATENCY,
    parameter int unsigned ADDR_W  = DATA_MEM_ADDR_W
) (
    input  logic          clock,
    input  logic          reset,
    data_memory_if.slave  bus
);

    localparam int unsigned      IDX_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

`ifdef DATA_MEM_CLEAR_EN
    localparam logic [STATE_W-1:0] RESET_STATE = ST_CLEAR;
`else
    localparam logic [STATE_W-1:0] RESET_STATE = ST_IDLE;
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic               op_write_q, op_write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    block_t             wdata_q, wdata_d;
    block_t             readdata_q, readdata_d;
    block_t             mem_q [DEPTH];

    logic               req_valid_c;
    logic               busywait_c;
    logic               cnt_load_c;
    logic               cnt_enable_c;
    logic               cnt_zero_c;
    logic               mem_we_c;
    logic [IDX_W-1:0]   mem_widx_c;
    block_t             mem_wdata_c;
    logic               addr_unused_c;

`ifdef DATA_MEM_CLEAR_EN
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
`endif

    // Simultaneous read and write is illegal and never starts an access.
    assign req_valid_c   = bus.read ^ bus.write;
    // Upper address bits alias onto the array.
    assign addr_unused_c = ^bus.address[ADDR_W-1:IDX_W];

    data_mem_latency_counter #(
        .WIDTH (CNT_W)
    ) u_latency (
        .clock    (clock),
        .reset    (reset),
        .load_i   (cnt_load_c),
        .value_i  (CNT_LOAD),
        .enable_i (cnt_enable_c),
        .zero_c_o (cnt_zero_c)
    );

    always_comb begin
        state_d      = state_q;
        op_write_d   = op_write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        readdata_d   = readdata_q;
        busywait_c   = 1'b0;
        cnt_load_c   = 1'b0;
        cnt_enable_c = 1'b0;
        mem_we_c     = 1'b0;
        mem_widx_c   = idx_q;
        mem_wdata_c  = wdata_q;
`ifdef DATA_MEM_CLEAR_EN
        clr_idx_d    = clr_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busywait_c = req_valid_c;
                if (req_valid_c) begin
                    op_write_d = bus.write;
                    idx_d      = bus.address[IDX_W-1:0];
                    wdata_d    = bus.writedata;
                    cnt_load_c = 1'b1;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busywait_c = 1'b1;
                if (cnt_zero_c) begin
                    state_d = ST_DONE;
                    if (op_write_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        readdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_enable_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
`ifdef DATA_MEM_CLEAR_EN
            ST_CLEAR: begin
                busywait_c  = 1'b1;
                mem_we_c    = 1'b1;
                mem_widx_c  = clr_idx_q;
                mem_wdata_c = '0;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
`ifdef DATA_MEM_CLEAR_EN
            clr_idx_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
`ifdef DATA_MEM_CLEAR_EN
            clr_idx_q  <= clr_idx_d;
`endif
        end
    end

    // Storage has no reset; write enable is derived from the async-reset FSM.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_q[mem_widx_c] <= mem_wdata_c;
        end
    end

    assign bus.busywait = busywait_c;
    assign bus.readdata = readdata_q;

endmodule
